// File: rtl/icache_fill_ctrl_pkg.sv
// icache_fill_ctrl_pkg: shared types and constants for the I-cache fill controller.
// Holds the memory-interface types (address, tag, block), the MSHR entry layout,
// the request-origin and FSM state encodings, and a block-alignment helper.
package icache_fill_ctrl_pkg;

   localparam int NUM_MEM_TAGS = 15;
   localparam int BLK_OFF      = 3;
   localparam int TAG_W        = $clog2(NUM_MEM_TAGS + 1);

   typedef logic [31:0]      ADDR;
   typedef logic [TAG_W-1:0] MEM_TAG;
   typedef logic [63:0]      MEM_BLOCK;

   typedef struct packed {
      logic valid;
      ADDR  addr;
   } ICACHE_FILL_ENTRY;

   typedef enum logic [0:0] {
      SRC_DEMAND   = 1'b0,
      SRC_PREFETCH = 1'b1
   } FILL_SRC;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } FILL_STATE;

   localparam ADDR BLK_MASK = {{(32 - BLK_OFF){1'b1}}, {BLK_OFF{1'b0}}};

   // Clear the byte-offset bits so every request names a whole block.
   function automatic ADDR blk_align(input ADDR a);
      return a & BLK_MASK;
   endfunction

endpackage

// File: rtl/icache_fill_mshr.sv
// icache_fill_mshr: tag-indexed table of outstanding line fills.
// One alloc port (write entry at the accepted tag), one free port (invalidate on
// return), an address CAM for dedup and a popcount of valid entries.
// When alloc and free name the same tag in one cycle the alloc wins.
module icache_fill_mshr
   import icache_fill_ctrl_pkg::*;
#(
   parameter  int NUM_TAGS = NUM_MEM_TAGS,
   localparam int CNT_W    = $clog2(NUM_TAGS + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             alloc_en,
   input  MEM_TAG           alloc_tag,
   input  ADDR              alloc_addr,
   input  logic             free_en,
   input  MEM_TAG           free_tag,
   input  ADDR              lookup_addr,
   output logic             lookup_hit,
   input  MEM_TAG           rd_tag,
   output ICACHE_FILL_ENTRY rd_entry,
   output logic [CNT_W-1:0] count
);

   ICACHE_FILL_ENTRY entries_q [NUM_TAGS+1];
   ICACHE_FILL_ENTRY entries_d [NUM_TAGS+1];

   assign rd_entry = entries_q[rd_tag];

   // Next table contents: free first, then alloc so a same-tag alloc overrides the free.
   always_comb begin
      for (int i = 0; i <= NUM_TAGS; i++) begin
         entries_d[i] = entries_q[i];
         if ((i != 0) && free_en && (free_tag == MEM_TAG'(i))) begin
            entries_d[i].valid = 1'b0;
         end else begin
            entries_d[i].valid = entries_q[i].valid;
         end
         if ((i != 0) && alloc_en && (alloc_tag == MEM_TAG'(i))) begin
            entries_d[i].valid = 1'b1;
            entries_d[i].addr  = alloc_addr;
         end else begin
            entries_d[i].addr  = entries_d[i].addr;
         end
      end
   end

   // Table register; tag 0 is never written so it stays invalid.
   always_ff @(posedge clock) begin
      for (int i = 0; i <= NUM_TAGS; i++) begin
         if (reset) begin
            entries_q[i] <= '0;
         end else begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

   // Address match and valid-entry count over the current (pre-free) state.
   always_comb begin
      count      = '0;
      lookup_hit = 1'b0;
      for (int i = 1; i <= NUM_TAGS; i++) begin
         count = count + CNT_W'(entries_q[i].valid);
         if (entries_q[i].valid && (entries_q[i].addr == lookup_addr)) begin
            lookup_hit = 1'b1;
         end else begin
            lookup_hit = lookup_hit;
         end
      end
   end

endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: sequences I-cache line fills.
// Arbitrates demand misses over prefetches, issues one memory read at a time via an
// IDLE/REQ FSM, tracks outstanding reads in icache_fill_mshr and writes returned
// blocks to the I-cache through a registered fill stage.
// Build option: define ICACHE_FILL_PREFETCH_EN to arbitrate the prefetch port;
// otherwise prefetch inputs are ignored and prefetch_ready is tied low.
module icache_fill_ctrl
   import icache_fill_ctrl_pkg::*;
#(
   parameter  int NUM_TAGS = NUM_MEM_TAGS,
   localparam int CNT_W    = $clog2(NUM_TAGS + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             demand_valid,
   input  logic [31:0]      demand_addr,
   output logic             demand_ready,
   input  logic             prefetch_valid,
   input  logic [31:0]      prefetch_addr,
   output logic             prefetch_ready,
   output logic             mem_req_valid,
   output logic [31:0]      mem_req_addr,
   input  logic [TAG_W-1:0] Imem2proc_transaction_tag,
   input  logic [63:0]      Imem2proc_data,
   input  logic [TAG_W-1:0] Imem2proc_data_tag,
   output logic             fill_valid,
   output logic [31:0]      fill_addr,
   output logic [63:0]      fill_data,
   output logic [CNT_W-1:0] outstanding_cnt
);

   FILL_STATE        state_q, state_d;
   ADDR              req_addr_q, req_addr_d;
   FILL_SRC          src_q, src_d;
   logic             fill_valid_q, fill_valid_d;
   ADDR              fill_addr_q, fill_addr_d;
   MEM_BLOCK         fill_data_q, fill_data_d;

   logic             pf_valid_s;
   ADDR              pf_addr_s;
   logic             sel_valid_s;
   FILL_SRC          sel_src_s;
   ADDR              sel_addr_s;
   logic             accept_s;
   logic             mshr_hit_s;
   logic             full_s;
   logic             alloc_en_s;
   logic             ret_hit_s;
   ICACHE_FILL_ENTRY ret_entry_s;
   logic [CNT_W-1:0] cnt_s;

`ifdef ICACHE_FILL_PREFETCH_EN
   assign pf_valid_s = prefetch_valid;
   assign pf_addr_s  = prefetch_addr;
`else
   logic unused_prefetch_s;
   assign pf_valid_s        = 1'b0;
   assign pf_addr_s         = '0;
   assign unused_prefetch_s = prefetch_valid ^ (^prefetch_addr);
`endif

   assign sel_valid_s = demand_valid | pf_valid_s;
   assign sel_src_s   = demand_valid ? SRC_DEMAND : SRC_PREFETCH;
   assign sel_addr_s  = blk_align(demand_valid ? demand_addr : pf_addr_s);
   assign full_s      = (cnt_s >= CNT_W'(NUM_TAGS));
   assign alloc_en_s  = (state_q == ST_REQ) && (Imem2proc_transaction_tag != '0);
   assign ret_hit_s   = (Imem2proc_data_tag != '0) && ret_entry_s.valid;

   icache_fill_mshr #(.NUM_TAGS(NUM_TAGS)) u_mshr (
      .clock       (clock),
      .reset       (reset),
      .alloc_en    (alloc_en_s),
      .alloc_tag   (Imem2proc_transaction_tag),
      .alloc_addr  (req_addr_q),
      .free_en     (ret_hit_s),
      .free_tag    (Imem2proc_data_tag),
      .lookup_addr (sel_addr_s),
      .lookup_hit  (mshr_hit_s),
      .rd_tag      (Imem2proc_data_tag),
      .rd_entry    (ret_entry_s),
      .count       (cnt_s)
   );

   // Arbitration and IDLE/REQ next state; duplicates are acked even when the MSHR is full.
   always_comb begin
      state_d        = state_q;
      req_addr_d     = req_addr_q;
      src_d          = src_q;
      accept_s       = 1'b0;
      demand_ready   = 1'b0;
      prefetch_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_valid_s && (mshr_hit_s || !full_s)) begin
               accept_s = 1'b1;
               if (!mshr_hit_s) begin
                  state_d    = ST_REQ;
                  req_addr_d = sel_addr_s;
                  src_d      = sel_src_s;
               end else begin
                  state_d    = ST_IDLE;
               end
            end else begin
               accept_s = 1'b0;
            end
         end
         ST_REQ: begin
            if (alloc_en_s) begin
               state_d = ST_IDLE;
            end else if (flush && (src_q == SRC_DEMAND)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (reset) begin
         demand_ready   = 1'b0;
         prefetch_ready = 1'b0;
      end else begin
         demand_ready   = accept_s && (sel_src_s == SRC_DEMAND);
         prefetch_ready = accept_s && (sel_src_s == SRC_PREFETCH);
      end
   end

   // Fill stage input: a return for a valid entry produces an I-cache write next cycle.
   always_comb begin
      if (ret_hit_s) begin
         fill_valid_d = 1'b1;
         fill_addr_d  = ret_entry_s.addr;
         fill_data_d  = Imem2proc_data;
      end else begin
         fill_valid_d = 1'b0;
         fill_addr_d  = '0;
         fill_data_d  = '0;
      end
   end

   // FSM, latched request and fill stage registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         req_addr_q   <= '0;
         src_q        <= SRC_DEMAND;
         fill_valid_q <= 1'b0;
         fill_addr_q  <= '0;
         fill_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         src_q        <= src_d;
         fill_valid_q <= fill_valid_d;
         fill_addr_q  <= fill_addr_d;
         fill_data_q  <= fill_data_d;
      end
   end

   assign mem_req_valid   = (state_q == ST_REQ);
   assign mem_req_addr    = req_addr_q;
   assign fill_valid      = fill_valid_q;
   assign fill_addr       = fill_addr_q;
   assign fill_data       = fill_data_q;
   assign outstanding_cnt = cnt_s;

endmodule
